// File: rtl/fcu_pkg.sv
// Shared definitions for the flit credit unit: port codes, port count
// and the default downstream buffer depth.
package fcu_pkg;

    localparam int NUM_PORTS     = 5;
    localparam int DEF_BUF_DEPTH = 4;

    localparam logic [2:0] PORT_NORTH = 3'd0;
    localparam logic [2:0] PORT_SOUTH = 3'd1;
    localparam logic [2:0] PORT_EAST  = 3'd2;
    localparam logic [2:0] PORT_WEST  = 3'd3;
    localparam logic [2:0] PORT_LOCAL = 3'd4;
    localparam logic [2:0] PORT_NONE  = 3'd5;

    // True when a request address targets the given output port code.
    // Codes PORT_NONE and above never match anything.
    function automatic logic port_hit(input logic [2:0] addr, input logic [2:0] code);
        return (addr < PORT_NONE) && (addr == code);
    endfunction

endpackage

// File: rtl/fcu_credit_cnt.sv
// One saturating credit counter for a single output port. The grant is
// derived only from the registered count, so it has no path from inputs.
module fcu_credit_cnt
    import fcu_pkg::*;
#(
    parameter int BUF_DEPTH = DEF_BUF_DEPTH,
    parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic consume_i,
    input  logic credit_i,
    output logic grant_o
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             consume_ok;
    logic             credit_ok;

    // A consume at zero is ignored (no underflow); a credit at full is dropped.
    assign consume_ok = consume_i && (cnt != CNT_ZERO);
    assign credit_ok  = credit_i  && (cnt != CNT_FULL);

    // Next count: simultaneous consume and credit cancel each other out.
    always_comb begin
        cnt_next = cnt;
        if (consume_i && credit_i) begin
            cnt_next = cnt;
        end else begin
            unique case ({consume_ok, credit_ok})
                2'b10:   cnt_next = cnt - CNT_ONE;
                2'b01:   cnt_next = cnt + CNT_ONE;
                default: cnt_next = cnt;
            endcase
        end
    end

    // Counter register; reset refills the downstream buffer credits.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= CNT_FULL;
        end else begin
            cnt <= cnt_next;
        end
    end

    assign grant_o = (cnt != CNT_ZERO);

endmodule

// File: rtl/fcu_modport.sv
// Five-port credit flow-control unit. Decodes the request addresses of
// the five input ports into one consume strobe per output port and keeps
// an independent credit counter for each output.
module fcu_modport
    import fcu_pkg::*;
#(
    parameter int BUF_DEPTH = DEF_BUF_DEPTH,
    parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req_port_addr1_i,
    input  logic [2:0]       req_port_addr2_i,
    input  logic [2:0]       req_port_addr3_i,
    input  logic [2:0]       req_port_addr4_i,
    input  logic [2:0]       req_port_addr5_i,
    input  logic             credit_en_north,
    input  logic             credit_en_south,
    input  logic             credit_en_east,
    input  logic             credit_en_west,
    input  logic             credit_en_local,
    output logic             grant_access_north,
    output logic             grant_access_south,
    output logic             grant_access_east,
    output logic             grant_access_west,
    output logic             grant_access_local
);

    localparam logic [2:0] PORT_CODE [NUM_PORTS] =
        '{PORT_NORTH, PORT_SOUTH, PORT_EAST, PORT_WEST, PORT_LOCAL};

    logic [2:0]           req_addr [NUM_PORTS];
    logic [NUM_PORTS-1:0] credit;
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] hit;
    logic [NUM_PORTS-1:0] consume;

    assign req_addr[0] = req_port_addr1_i;
    assign req_addr[1] = req_port_addr2_i;
    assign req_addr[2] = req_port_addr3_i;
    assign req_addr[3] = req_port_addr4_i;
    assign req_addr[4] = req_port_addr5_i;

    assign credit = {credit_en_local, credit_en_west, credit_en_east,
                     credit_en_south, credit_en_north};

    // Any number of inputs naming a port collapse into one consume strobe.
    always_comb begin
        hit = {NUM_PORTS{1'b0}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int n = 0; n < NUM_PORTS; n++) begin
                if (port_hit(req_addr[n], PORT_CODE[p])) begin
                    hit[p] = 1'b1;
                end else begin
                    hit[p] = hit[p];
                end
            end
        end
    end

    assign consume = hit & grant;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
        fcu_credit_cnt #(
            .BUF_DEPTH (BUF_DEPTH),
            .CNT_W     (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .consume_i (consume[p]),
            .credit_i  (credit[p]),
            .grant_o   (grant[p])
        );
    end

    assign grant_access_north = grant[0];
    assign grant_access_south = grant[1];
    assign grant_access_east  = grant[2];
    assign grant_access_west  = grant[3];
    assign grant_access_local = grant[4];

endmodule

// File: tb/tb_fcu_modport.sv
// Self-checking bench for fcu_modport. A reference credit model predicts
// the grant vector for each cycle; predictions are queued when stimulus
// is applied and popped when the DUT outputs are sampled after the edge.
module tb_fcu_modport;

    localparam int BD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] a1 = 3'd5, a2 = 3'd5, a3 = 3'd5, a4 = 3'd5, a5 = 3'd5;
    logic       cn = 1'b0, cs = 1'b0, ce = 1'b0, cw = 1'b0, cl = 1'b0;
    logic       gn, gs, ge, gw, gl;
    logic [4:0] gv;

    int         checks   = 0;
    int         failures = 0;
    int         mcnt [5];
    logic [4:0] sb [$];
    logic [4:0] e;

    assign gv = {gl, gw, ge, gs, gn};

    always #5 clk = ~clk;

    fcu_modport #(.BUF_DEPTH(BD), .CNT_W(3)) dut (
        .clk                (clk),
        .rst                (rst),
        .req_port_addr1_i   (a1),
        .req_port_addr2_i   (a2),
        .req_port_addr3_i   (a3),
        .req_port_addr4_i   (a4),
        .req_port_addr5_i   (a5),
        .credit_en_north    (cn),
        .credit_en_south    (cs),
        .credit_en_east     (ce),
        .credit_en_west     (cw),
        .credit_en_local    (cl),
        .grant_access_north (gn),
        .grant_access_south (gs),
        .grant_access_east  (ge),
        .grant_access_west  (gw),
        .grant_access_local (gl)
    );

    // Drive one cycle of stimulus, advance the reference model, queue the
    // grant vector expected after the edge, then step past the edge.
    task automatic apply(input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] r3,
                         input logic [2:0] r4, input logic [2:0] r5,
                         input logic [4:0] cred, input logic do_rst);
        logic [2:0] addrs [5];
        logic [4:0] exp_v;
        logic       g, h;
        a1 = r1; a2 = r2; a3 = r3; a4 = r4; a5 = r5;
        {cl, cw, ce, cs, cn} = cred;
        rst = do_rst;
        addrs[0] = r1; addrs[1] = r2; addrs[2] = r3; addrs[3] = r4; addrs[4] = r5;
        for (int p = 0; p < 5; p++) begin
            g = (mcnt[p] != 0);
            h = 1'b0;
            for (int n = 0; n < 5; n++) if (int'(addrs[n]) == p) h = 1'b1;
            if (do_rst) mcnt[p] = BD;
            else if (h && g && !cred[p]) mcnt[p] = mcnt[p] - 1;
            else if (cred[p] && !(h && g) && mcnt[p] < BD) mcnt[p] = mcnt[p] + 1;
            exp_v[p] = (mcnt[p] != 0);
        end
        sb.push_back(exp_v);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Reset with requests and credits active: reset must win.
        apply(3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 5'b11111, 1'b1);
        e = sb.pop_front();
        checks++;
        if (gv !== e || gv !== 5'b11111) begin
            failures++;
            $display("FAIL reset_grants got=%b exp=%b", gv, 5'b11111);
        end
        // Idle reset, then drain all ports together to prove each holds exactly 4.
        apply(3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 5'b00000, 1'b1);
        e = sb.pop_front();
        checks++;
        if (gv !== e) begin failures++; $display("FAIL reset_idle got=%b exp=%b", gv, e); end
        for (int i = 0; i < 5; i++) begin
            apply(3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 5'b00000, 1'b0);
            e = sb.pop_front();
            checks++;
            if (gv !== e) begin failures++; $display("FAIL reset_depth cyc=%0d got=%b exp=%b", i, gv, e); end
        end
    endtask

    task automatic test_drain_north();
        logic seq [5];
        seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        apply(3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 5'b00000, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            a1 = 3'd0;
            #1;
            checks++;
            if (gn !== seq[i]) begin failures++; $display("FAIL north_seq cyc=%0d got=%b exp=%b", i, gn, seq[i]); end
            apply((i < 4) ? 3'd0 : 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 5'b00000, 1'b0);
            e = sb.pop_front();
            checks++;
            if (gv !== e) begin failures++; $display("FAIL north_sb cyc=%0d got=%b exp=%b", i, gv, e); end
        end
        cn = 1'b1;
        #1;
        checks++;
        if (gn !== 1'b0) begin failures++; $display("FAIL north_credit_same_cycle got=%b exp=0", gn); end
        apply(3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 5'b00001, 1'b0);
        e = sb.pop_front();
        checks++;
        if (gv !== e || gn !== 1'b1) begin failures++; $display("FAIL north_credit_next got=%b exp=%b", gv, e); end
    endtask

    task automatic test_multi_req_east();
        apply(3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 5'b00000, 1'b1);
        void'(sb.pop_front());
        apply(3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 5'b00000, 1'b0);
        void'(sb.pop_front());
        // Three more single requests: grant must only drop after the last.
        for (int i = 0; i < 3; i++) begin
            apply(3'd2, 3'd5, 3'd5, 3'd5, 3'd5, 5'b00000, 1'b0);
            e = sb.pop_front();
            checks++;
            if (gv !== e) begin failures++; $display("FAIL east_multi cyc=%0d got=%b exp=%b", i, gv, e); end
        end
    endtask

    task automatic test_west_saturate();
        apply(3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 5'b00000, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            apply(3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 5'b01000, 1'b0);
            e = sb.pop_front();
            checks++;
            if (gv !== e || gw !== 1'b1) begin failures++; $display("FAIL west_sat cyc=%0d got=%b exp=%b", i, gv, e); end
        end
        for (int i = 0; i < 4; i++) begin
            apply(3'd5, 3'd5, 3'd5, 3'd3, 3'd5, 5'b00000, 1'b0);
            e = sb.pop_front();
            checks++;
            if (gv !== e) begin failures++; $display("FAIL west_drain cyc=%0d got=%b exp=%b", i, gv, e); end
        end
    endtask

    task automatic test_local_simul();
        apply(3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 5'b00000, 1'b1);
        void'(sb.pop_front());
        apply(3'd5, 3'd5, 3'd5, 3'd5, 3'd4, 5'b00000, 1'b0);
        void'(sb.pop_front());
        apply(3'd5, 3'd5, 3'd5, 3'd5, 3'd4, 5'b00000, 1'b0);
        void'(sb.pop_front());
        apply(3'd4, 3'd5, 3'd5, 3'd5, 3'd5, 5'b10000, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 2; i++) begin
            apply(3'd5, 3'd4, 3'd5, 3'd5, 3'd5, 5'b00000, 1'b0);
            e = sb.pop_front();
            checks++;
            if (gv !== e) begin failures++; $display("FAIL local_simul cyc=%0d got=%b exp=%b", i, gv, e); end
        end
    endtask

    task automatic test_south_underflow_reset();
        apply(3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 5'b00000, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 6; i++) begin
            apply(3'd5, 3'd1, 3'd5, 3'd5, 3'd5, 5'b00000, 1'b0);
            e = sb.pop_front();
            checks++;
            if (gv !== e) begin failures++; $display("FAIL south_drain cyc=%0d got=%b exp=%b", i, gv, e); end
        end
        // Still requesting while empty, then reset overrides the request.
        apply(3'd5, 3'd1, 3'd5, 3'd5, 3'd5, 5'b00000, 1'b1);
        e = sb.pop_front();
        checks++;
        if (gv !== e || gs !== 1'b1) begin failures++; $display("FAIL south_reset got=%b exp=%b", gv, e); end
    endtask

    task automatic test_back_to_back_random();
        logic [2:0] r [5];
        for (int i = 0; i < 300; i++) begin
            for (int n = 0; n < 5; n++) r[n] = 3'($urandom_range(0, 7));
            apply(r[0], r[1], r[2], r[3], r[4], 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 59) == 0));
            e = sb.pop_front();
            checks++;
            if (gv !== e) begin failures++; $display("FAIL random cyc=%0d got=%b exp=%b", i, gv, e); end
        end
    endtask

    initial begin
        for (int p = 0; p < 5; p++) mcnt[p] = 0;
        test_reset();
        test_drain_north();
        test_multi_req_east();
        test_west_saturate();
        test_local_simul();
        test_south_underflow_reset();
        test_back_to_back_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fcu_modport.md
FCU_MODPORT -- requirements
Module: fcu_modport

Interface
REQ-001 Parameter BUF_DEPTH, default 4: flit slots in each downstream input buffer (legal 1..7).
REQ-002 Parameter CNT_W, default 3: credit counter width; SHALL equal $clog2(BUF_DEPTH+1).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_port_addr1_i..req_port_addr5_i  input  3 each  output port requested this cycle by input ports 1..5.
REQ-006 credit_en_north/south/east/west/local  input  1 each  one credit returned by that downstream neighbour this cycle.
REQ-007 grant_access_north/south/east/west/local  output  1 each  that output port may accept a flit this cycle.

Function
REQ-008 Port encoding SHALL be: 0 north, 1 south, 2 east, 3 west, 4 local; codes 5..7 mean no request and SHALL be ignored.
REQ-009 Each of the 5 output ports SHALL hold one independent credit counter, cnt_P, range 0..BUF_DEPTH.
REQ-010 grant_access_P SHALL equal (cnt_P != 0).
REQ-011 grant_access_P SHALL be driven combinationally from the registered cnt_P only, so it has no combinational path from any input.
REQ-012 consume_P SHALL be 1 when at least one req_port_addrN_i equals P and grant_access_P is 1.
REQ-013 A port consumes at most one credit per cycle, even when several inputs request the same port; arbitration among those inputs is outside this block.
REQ-014 Per cycle: consume_P only -> cnt_P-1; credit_en_P only -> cnt_P+1; both -> cnt_P unchanged; neither -> unchanged.
REQ-015 A credit_en_P arriving while cnt_P==BUF_DEPTH SHALL be dropped, so cnt_P saturates at BUF_DEPTH.
REQ-016 A request to P while cnt_P==0 SHALL not change cnt_P (no underflow); grant_access_P stays 0.
REQ-017 grant_access_P is 0 in the cycle when cnt_P==0, even if credit_en_P is 1 that cycle.
REQ-018 The restored credit from REQ-017 is visible on grant_access_P in the following cycle.
REQ-019 Ports are fully independent; any combination of simultaneous requests and credits on different ports is legal.
REQ-020 Latency: a consume or credit event changes grant_access_P one cycle after the clock edge that samples it.

Reset
REQ-021 When rst=1 at a rising clk edge, every cnt_P SHALL load BUF_DEPTH.
REQ-022 Consequently, all five grant_access outputs SHALL read 1 after reset.
REQ-023 Reset SHALL override any simultaneous requests or credits in that cycle.
REQ-024 Reset asserted mid-operation SHALL restore the counters to full in the same way.

Structure
REQ-025 A shared package fcu_pkg SHALL hold the port codes (PORT_NORTH..PORT_LOCAL, PORT_NONE=5), NUM_PORTS=5 and the default BUF_DEPTH.
REQ-026 A sub-module fcu_credit_cnt SHALL implement one counter: ports clk, rst, consume_i, credit_i, grant_o.
REQ-027 The top level SHALL instantiate fcu_credit_cnt five times and decode the five request addresses into the consume_P signals.

Verification
REQ-028 Reset with all requests 5 and no credits -> all five grants are 1 and every counter is 4.
REQ-029 Scenario: req_port_addr1_i=0 for 4 consecutive cycles, no credits.
- grant_access_north reads 1,1,1,1 during those cycles, then 0.
- Pulsing credit_en_north once afterwards -> grant_access_north is 1 one cycle later.
REQ-030 Inputs 1, 2 and 3 all request 2 (east) for 1 cycle -> cnt_east goes from 4 to 3, not 1.
REQ-031 With cnt_west=4, pulse credit_en_west 3 cycles -> cnt_west stays 4 and grant_access_west stays 1.
REQ-032 Scenario: cnt_local=2, then 1 cycle with a request to 4 and credit_en_local=1 together -> cnt_local stays 2.
REQ-033 Scenario: drain south to 0, request south for 2 more cycles, then assert rst.
- Counter holds at 0 and grant_access_south is 0 while requests continue.
- Next cycle after rst, grant_access_south is 1 again.
